even_decoder: RTL and testbench
===============================

Name: even_decoder

Overview:
- Registered even/odd classifier and one-hot decoder for a W-bit unsigned sample.
- Sits on a datapath tap: each valid sample is flagged even or odd, decoded to one-hot, and even samples are counted.
- One clock domain. All outputs are registered, with 1-cycle latency.

Parameters:
- W, 4: input sample width in bits; legal range 1..8.
- CNT_W, 8: width of the even-sample counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- a  input  W  unsigned sample to classify.
- in_valid  input  1  a is valid this cycle.
- clr_cnt  input  1  synchronous clear of even_cnt.
- y  output  1  registered even flag: 1 when the last accepted a had bit0 == 0.
- odd  output  1  registered odd flag; always equals ~y after the first accepted sample.
- out_valid  output  1  high for exactly one cycle after each accepted sample.
- onehot  output  2**W  registered one-hot decode: bit[a] set for the last accepted a.
- parity  output  1  registered XOR-reduction of the last accepted a (see Optional Feature).
- even_cnt  output  CNT_W  saturating count of accepted even samples.

Behaviour:
- Reset: when rst_n is 0 at a rising edge, the following registers clear on that edge: y=0, odd=0, out_valid=0, onehot=0, parity=0, even_cnt=0.
  - Reset has priority over all other inputs.
  - Reset asserted mid-stream discards the sample presented in that cycle.
- Accept: a sample is accepted on a rising edge with rst_n=1 and in_valid=1.
  - Next cycle: y = ~a[0], odd = a[0], onehot = 1<<a, out_valid=1.
- Idle: with in_valid=0, out_valid goes to 0. y, odd, onehot and parity hold their last values.
- Latency: exactly 1 clock from accept to outputs. Back-to-back valid samples are accepted every cycle with no bubbles.
- Even classification uses only a[0].
  - a=0 counts as even.
  - The all-ones value (15 when W=4) is odd.
- even_cnt update, in priority order:
  - rst_n=0 clears it.
  - Else clr_cnt=1 clears it. If clr_cnt coincides with an accepted even sample, clear wins and the result is 0.
  - Else an accepted even sample increments it by 1.
  - At 2**CNT_W-1 it saturates and does not wrap.
- onehot has exactly one bit set after the first accepted sample, and all zeros before it.
- No combinational path from any input to any output.

Optional Feature:
- Macro: EVEN_DECODER_PARITY_EN.
- Defined: on accept, parity registers ^a (1 when a has an odd number of set bits). It holds when idle and clears on reset.
- Undefined: the parity port still exists and is tied constant 0. No parity logic is instantiated.

Test Plan:
- Reset then sweep: hold rst_n=0 for 2 cycles, then present a=0..15 with in_valid=1 every cycle.
  -> One cycle after each a: y=1 for a in {0,2,...,14} and 0 otherwise; odd=~y; onehot=1<<a; out_valid=1.
  -> After the sweep, even_cnt=8.
- Idle hold: accept a=6, then drive in_valid=0 with a=7 for 3 cycles.
  -> y stays 1, onehot stays 0x0040, out_valid is 0 and even_cnt is unchanged.
- Counter clear collision: with even_cnt=5, assert clr_cnt=1 in the same cycle an even a=4 is accepted.
  -> Next cycle even_cnt=0 and y=1.
- Saturation: with CNT_W=3, accept 10 even samples.
  -> even_cnt reaches 7 and stays 7.
- Reset mid-stream: accept a=3, then in the next cycle drive rst_n=0 with in_valid=1, a=2.
  -> All outputs are 0 next cycle and even_cnt=0.
- Parity (EVEN_DECODER_PARITY_EN defined): accept a=7, then a=5.
  -> parity=1, then parity=0.
  -> Without the macro, parity is 0 for the same stimulus.

Source files
------------

// File: rtl/even_decoder.sv
// even_decoder
//   Registered even/odd classifier and one-hot decoder for a W-bit unsigned
//   sample. Each accepted sample (in_valid=1) is flagged even/odd, decoded to
//   one-hot and, if even, counted. All outputs are registered with a latency
//   of one clock.
//
//   Optional feature macro: EVEN_DECODER_PARITY_EN
//     defined   -> parity registers ^a on accept, holds when idle.
//     undefined -> parity is tied to 0 and no parity register exists.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset (priority over everything)
//   a         : W-bit unsigned sample
//   in_valid  : a is valid this cycle
//   clr_cnt   : synchronous clear of even_cnt (wins over increment)
//   y         : even flag of last accepted sample
//   odd       : odd flag of last accepted sample
//   out_valid : one-cycle pulse after each accepted sample
//   onehot    : 1 << last accepted a (zero before the first accept)
//   parity    : XOR-reduction of last accepted a (or 0, see macro)
//   even_cnt  : saturating count of accepted even samples
module even_decoder #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         a,
  input  logic                 in_valid,
  input  logic                 clr_cnt,
  output logic                 y,
  output logic                 odd,
  output logic                 out_valid,
  output logic [(1<<W)-1:0]    onehot,
  output logic                 parity,
  output logic [CNT_W-1:0]     even_cnt
);

  localparam int N = 1 << W;
  localparam logic [N-1:0]     ONE     = N'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Only bit 0 decides even/odd.
  logic is_even;
  assign is_even = ~a[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y         <= 1'b0;
      odd       <= 1'b0;
      out_valid <= 1'b0;
      onehot    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y      <= is_even;
        odd    <= a[0];
        onehot <= ONE << a;
      end
    end
  end

  // Clear beats a coincident even accept; count pins at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n)
      even_cnt <= '0;
    else if (clr_cnt)
      even_cnt <= '0;
    else if (in_valid && is_even && (even_cnt != CNT_MAX))
      even_cnt <= even_cnt + CNT_W'(1);
  end

`ifdef EVEN_DECODER_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      parity <= 1'b0;
    else if (in_valid)
      parity <= ^a;
  end
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_even_decoder.sv
// Bench for even_decoder: two instances (CNT_W=8 and CNT_W=3) share one
// stimulus stream. A behavioural model tracks the last accepted sample and
// the even counts; a negedge process compares every output each cycle, and
// directed scenarios add literal expectations.
module tb_even_decoder;
  localparam int W = 4;

`ifdef EVEN_DECODER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, in_valid, clr_cnt;
  logic [W-1:0] a;

  logic y8, odd8, ov8, par8;
  logic [15:0] oh8;
  logic [7:0]  cnt8;
  logic y3, odd3, ov3, par3;
  logic [15:0] oh3;
  logic [2:0]  cnt3;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  even_decoder #(.W(W), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid), .clr_cnt(clr_cnt),
    .y(y8), .odd(odd8), .out_valid(ov8), .onehot(oh8), .parity(par8),
    .even_cnt(cnt8));

  even_decoder #(.W(W), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid), .clr_cnt(clr_cnt),
    .y(y3), .odd(odd3), .out_valid(ov3), .onehot(oh3), .parity(par3),
    .even_cnt(cnt3));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what was last accepted, and how many evens were seen.
  int m_last = -1;
  bit m_vld  = 1'b0;
  int m_cnt8 = 0;
  int m_cnt3 = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_last = -1; m_vld = 1'b0; m_cnt8 = 0; m_cnt3 = 0;
    end else begin
      m_vld = in_valid;
      if (clr_cnt) begin
        m_cnt8 = 0; m_cnt3 = 0;
      end else if (in_valid && (int'(a) % 2 == 0)) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt3 < 7)   m_cnt3++;
      end
      if (in_valid) m_last = int'(a);
    end
  end

  function automatic logic [63:0] e_onehot();
    return (m_last < 0) ? 64'd0 : (64'd1 << m_last);
  endfunction
  function automatic logic e_y();
    return (m_last >= 0) && (m_last % 2 == 0);
  endfunction
  function automatic logic e_odd();
    return (m_last >= 0) && (m_last % 2 == 1);
  endfunction
  function automatic logic e_par();
    if (!PAR_EN || m_last < 0) return 1'b0;
    return ($countones(m_last) % 2) == 1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("y",        64'(y8),   64'(e_y()));
      chk("odd",      64'(odd8), 64'(e_odd()));
      chk("out_valid",64'(ov8),  64'(m_vld));
      chk("onehot",   64'(oh8),  e_onehot());
      chk("parity",   64'(par8), 64'(e_par()));
      chk("cnt8",     64'(cnt8), 64'(m_cnt8));
      chk("cnt3",     64'(cnt3), 64'(m_cnt3));
      chk("y3",       64'(y3),   64'(e_y()));
      chk("onehot3",  64'(oh3),  e_onehot());
      chk("ov3",      64'(ov3),  64'(m_vld));
      chk("odd3",     64'(odd3), 64'(e_odd()));
      chk("par3",     64'(par3), 64'(e_par()));
    end
  end

  task automatic step(input logic [W-1:0] av, input logic v, input logic c);
    a = av; in_valid = v; clr_cnt = c;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0; a = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_y",      64'(y8),   64'd0);
    chk("rst_onehot", 64'(oh8),  64'd0);
    chk("rst_cnt",    64'(cnt8), 64'd0);
    chk("rst_ov",     64'(ov8),  64'd0);
    rst_n = 1'b1;

    // Sweep 0..15 back to back.
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 1'b1, 1'b0);
      chk("sweep_oh", 64'(oh8), 64'd1 << i);
      chk("sweep_y",  64'(y8),  64'((i % 2) == 0));
      chk("sweep_ov", 64'(ov8), 64'd1);
    end
    chk("sweep_cnt8", 64'(cnt8), 64'd8);
    chk("sweep_cnt3", 64'(cnt3), 64'd7);

    // Idle hold.
    step(4'd6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'd7, 1'b0, 1'b0);
    chk("idle_y",   64'(y8),   64'd1);
    chk("idle_oh",  64'(oh8),  64'h0040);
    chk("idle_ov",  64'(ov8),  64'd0);
    chk("idle_cnt", 64'(cnt8), 64'd9);

    // Clear colliding with an even accept.
    step(4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(4'd2, 1'b1, 1'b0);
    chk("pre_clr_cnt", 64'(cnt8), 64'd5);
    step(4'd4, 1'b1, 1'b1);
    chk("clr_cnt", 64'(cnt8), 64'd0);
    chk("clr_y",   64'(y8),   64'd1);

    // Saturation of the 3-bit counter.
    for (int i = 0; i < 10; i++) step(4'($urandom_range(0, 7) * 2), 1'b1, 1'b0);
    chk("sat_cnt3", 64'(cnt3), 64'd7);
    chk("sat_cnt8", 64'(cnt8), 64'd10);

    // Reset mid-stream discards the sample.
    step(4'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(4'd2, 1'b1, 1'b0);
    chk("mrst_y",   64'(y8),   64'd0);
    chk("mrst_odd", 64'(odd8), 64'd0);
    chk("mrst_oh",  64'(oh8),  64'd0);
    chk("mrst_ov",  64'(ov8),  64'd0);
    chk("mrst_cnt", 64'(cnt8), 64'd0);
    rst_n = 1'b1;

    // Parity.
    step(4'd7, 1'b1, 1'b0);
    chk("par_7", 64'(par8), 64'(PAR_EN));
    step(4'd5, 1'b1, 1'b0);
    chk("par_5", 64'(par8), 64'd0);

    // Random traffic, model-checked each cycle.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 19) == 0));
    end
    rst_n = 1'b1;
    step(4'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
